serial_add_sub_unit: RTL and testbench



---
 rtl/serial_add_sub_unit.sv | 150 +++++++++++++++
 tb/tb_serial_add_sub_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_unit.sv
// Bit-serial adder/subtractor built around a 1-bit gate-level full-adder cell.
// Both operands are latched into shift registers, one bit pair per cycle is
// fed LSB-first into the cell with a registered carry, and the sum is shifted
// into a result register. Result and flags update after WIDTH cycles.

// Gate-level 1-bit full adder cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign s    = ab_x ^ cin;
  assign c    = (a & b) | (ab_x & cin);

endmodule

module serial_add_sub_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  // Bit index of the MSB and of the bit just below it.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy;
  logic             cy_msb_in;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sum_final;

  // One shared full-adder cell does all the arithmetic, one bit per cycle.
  full_adder_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (cy),
    .s   (fa_s),
    .c   (fa_c)
  );

  // A new request is taken from IDLE or DONE only; RUN ignores start.
  assign accept    = start && (state != S_RUN);
  assign last_bit  = (state == S_RUN) && (cnt == CNT_LAST);
  // Completed sum including the MSB bit produced on the final cycle.
  assign sum_final = {fa_s, s_sh[WIDTH-1:1]};

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy during RUN, done for the single DONE cycle.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Datapath: operand load, bit-serial shift/accumulate, result and flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      cy        <= 1'b0;
      cy_msb_in <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      a_sh <= op_a;
      b_sh <= sub ? ~op_b : op_b;
      cy   <= sub;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      s_sh <= {fa_s, s_sh[WIDTH-1:1]};
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      cy   <= fa_c;
      cnt  <= cnt + CNT_W'(1);
      // Carry into the MSB, needed for signed overflow detection.
      if (cnt == CNT_MSB_IN) begin
        cy_msb_in <= fa_c;
      end
      if (last_bit) begin
        result    <= sum_final;
        carry_out <= fa_c;
        overflow  <= fa_c ^ cy_msb_in;
        zero      <= (sum_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Self-checking bench for serial_add_sub_unit (WIDTH=32): a table of directed
// vectors with hand-computed results, plus sequences for start-during-RUN,
// back-to-back operation and reset in the middle of an operation.
`timescale 1ns/1ps

module tb_serial_add_sub_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int checks = 0;
  int errors = 0;

  serial_add_sub_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_result;
    logic             exp_c;
    logic             exp_v;
    logic             exp_z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation, let the accept edge pass, then scramble the inputs.
  task automatic apply_start(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    sub   = ~s;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Count edges until done is seen (bounded), and cycles with busy high.
  task automatic wait_done(input int limit, output int edges, output int busy_cycles);
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < limit) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_flags(input string tag, input logic [WIDTH-1:0] r,
                             input logic c, input logic v, input logic z);
    check({tag, " result"},    64'(result),    64'(r));
    check({tag, " carry_out"}, 64'(carry_out), 64'(c));
    check({tag, " overflow"},  64'(overflow),  64'(v));
    check({tag, " zero"},      64'(zero),      64'(z));
  endtask

  initial begin
    int edges;
    int busy_cycles;

    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check_flags("reset", '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors: latency, busy length, one-cycle done, result/flags.
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply_start(vecs[i].sub, vecs[i].a, vecs[i].b);
      wait_done(WIDTH + 8, edges, busy_cycles);
      check({tag, " latency"},     64'(edges),       64'(WIDTH));
      check({tag, " busy cycles"}, 64'(busy_cycles), 64'(WIDTH));
      check({tag, " done"},        64'(done),        64'd1);
      check({tag, " busy at done"}, 64'(busy),       64'd0);
      check_flags(tag, vecs[i].exp_result, vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z);
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, 64'(done), 64'd0);
      check({tag, " idle busy"},  64'(busy), 64'd0);
    end

    // start pulsed during RUN cycle 5 with different operands is ignored.
    apply_start(1'b0, 32'h0000_0005, 32'h0000_0007);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    sub   = 1'b1;
    op_a  = 32'h0000_0100;
    op_b  = 32'h0000_0200;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore busy", 64'(busy), 64'd1);
    wait_done(WIDTH + 8, edges, busy_cycles);
    check("ignore latency", 64'(edges + 5), 64'(WIDTH));
    check("ignore done", 64'(done), 64'd1);
    check_flags("ignore", 32'h0000_000C, 1'b0, 1'b0, 1'b0);

    // start held during DONE: second op accepted, done 33 edges after first.
    @(posedge clk);
    #1;
    apply_start(1'b0, 32'h1234_5678, 32'h1111_1111);
    wait_done(WIDTH + 8, edges, busy_cycles);
    check("b2b first done", 64'(done), 64'd1);
    check_flags("b2b first", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    apply_start(1'b1, 32'h8000_0000, 32'h0000_0001);
    check("b2b accepted busy", 64'(busy), 64'd1);
    wait_done(WIDTH + 8, edges, busy_cycles);
    check("b2b spacing", 64'(edges + 1), 64'(WIDTH + 1));
    check("b2b second done", 64'(done), 64'd1);
    check_flags("b2b second", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Reset for one edge at RUN cycle 10 clears everything.
    @(posedge clk);
    #1;
    apply_start(1'b0, 32'h0000_0005, 32'h0000_0007);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check_flags("midreset", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("midreset stays idle", 64'(busy), 64'd0);

    // A later operation completes normally.
    apply_start(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(WIDTH + 8, edges, busy_cycles);
    check("post-reset latency", 64'(edges), 64'(WIDTH));
    check("post-reset done", 64'(done), 64'd1);
    check_flags("post-reset", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
